// File: rtl/lock_pkg.sv
// Shared types and constants for the combination-lock controller.
package lock_pkg;

    typedef enum logic [2:0] {
        ST_ENTRY   = 3'd0,
        ST_CHECK   = 3'd1,
        ST_OPEN    = 3'd2,
        ST_SETPW   = 3'd3,
        ST_LOCKOUT = 3'd4
    } state_t;

    localparam logic [3:0] KEY_STAR      = 4'd10;
    localparam logic [3:0] KEY_HASH      = 4'd11;
    localparam logic [3:0] KEY_DIGIT_MAX = 4'd9;

endpackage

// File: rtl/lock_ctrl_if.sv
// Key-event input and status/indicator outputs of the lock controller.
interface lock_ctrl_if #(
    parameter int PW_LEN = 4
);
    logic                  key_valid;
    logic [3:0]            key_code;
    logic                  unlocked;
    logic                  alarm;
    logic                  ok_pulse;
    logic                  err_pulse;
    logic [3:0]            entry_cnt;
    logic [PW_LEN*4-1:0]   entry_buf;
    logic [2:0]            st;

    modport master (
        output key_valid, key_code,
        input  unlocked, alarm, ok_pulse, err_pulse, entry_cnt, entry_buf, st
    );

    modport slave (
        input  key_valid, key_code,
        output unlocked, alarm, ok_pulse, err_pulse, entry_cnt, entry_buf, st
    );
endinterface

// File: rtl/lock_timer.sv
// 32-bit loadable down-counter; expire fires on the last counted cycle so a
// load of N gives a dwell of exactly N enabled cycles.
module lock_timer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic [31:0] i_load_val,
    input  logic        i_en,
    output logic        o_expire
);
    logic [31:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_load_val;
        else if (i_en && (r_cnt != '0))
            r_cnt <= r_cnt - 32'd1;
    end

    assign o_expire = i_en && (r_cnt == 32'd1);
endmodule

// File: rtl/lock_ctrl.sv
// Combination-lock sequencer: password entry, check, unlock, change, lockout.
//   state   | meaning
//   ENTRY   | collecting digits of a password attempt
//   CHECK   | one-cycle compare of the buffer against the stored password
//   OPEN    | lock open until '#' or idle timeout; '*' enters SETPW
//   SETPW   | lock open, collecting a new password
//   LOCKOUT | alarm raised after too many failures, all keys ignored
module lock_ctrl
    import lock_pkg::*;
#(
    parameter int                   PW_LEN         = 4,
    parameter logic [PW_LEN*4-1:0]  DEFAULT_PW     = 16'h1234,
    parameter int                   MAX_FAIL       = 3,
    parameter logic [31:0]          OPEN_CYCLES    = 32'd250_000_000,
    parameter logic [31:0]          LOCKOUT_CYCLES = 32'd500_000_000
) (
    input logic        clk,
    input logic        rst_n,
    lock_ctrl_if.slave bus
);
    localparam int BW = PW_LEN * 4;
    localparam int FW = $clog2(MAX_FAIL + 1);

    state_t          r_state, w_state_nx;
    logic [BW-1:0]   r_buf, w_buf_nx, r_pw, w_pw_nx, w_pushed;
    logic [3:0]      r_cnt, w_cnt_nx;
    logic [FW-1:0]   r_fail, w_fail_nx;
    logic            r_ok, w_ok_nx, r_err, w_err_nx;
    logic            w_digit, w_star, w_hash, w_full;
    logic            w_load, w_tmr_en, w_expire;
    logic [31:0]     w_load_val;

    assign w_digit  = bus.key_valid && (bus.key_code <= KEY_DIGIT_MAX);
    assign w_star   = bus.key_valid && (bus.key_code == KEY_STAR);
    assign w_hash   = bus.key_valid && (bus.key_code == KEY_HASH);
    assign w_full   = (r_cnt == 4'(PW_LEN));
    assign w_pushed = {r_buf[BW-5:0], bus.key_code};
    assign w_tmr_en = (r_state == ST_OPEN) || (r_state == ST_SETPW) || (r_state == ST_LOCKOUT);

    lock_timer u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_en       (w_tmr_en),
        .o_expire   (w_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_ENTRY;
            r_buf   <= '0;
            r_cnt   <= '0;
            r_pw    <= DEFAULT_PW;
            r_fail  <= '0;
            r_ok    <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_buf   <= w_buf_nx;
            r_cnt   <= w_cnt_nx;
            r_pw    <= w_pw_nx;
            r_fail  <= w_fail_nx;
            r_ok    <= w_ok_nx;
            r_err   <= w_err_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_buf_nx   = r_buf;
        w_cnt_nx   = r_cnt;
        w_pw_nx    = r_pw;
        w_fail_nx  = r_fail;
        w_ok_nx    = 1'b0;
        w_err_nx   = 1'b0;
        w_load     = 1'b0;
        w_load_val = OPEN_CYCLES;
        case (r_state)
            ST_ENTRY: begin
                if (w_digit) begin
                    if (!w_full) begin
                        w_buf_nx = w_pushed;
                        w_cnt_nx = r_cnt + 4'd1;
                    end
                end else if (w_star) begin
                    w_buf_nx = '0;
                    w_cnt_nx = '0;
                end else if (w_hash) begin
                    if (w_full) begin
                        w_state_nx = ST_CHECK;
                    end else begin
                        w_err_nx = 1'b1;
                        w_buf_nx = '0;
                        w_cnt_nx = '0;
                    end
                end
            end
            ST_CHECK: begin
                w_buf_nx = '0;
                w_cnt_nx = '0;
                if (r_buf == r_pw) begin
                    w_ok_nx    = 1'b1;
                    w_fail_nx  = '0;
                    w_load     = 1'b1;
                    w_state_nx = ST_OPEN;
                end else begin
                    w_err_nx = 1'b1;
                    // Reaching the limit saturates the counter and starts lockout
                    if (r_fail >= FW'(MAX_FAIL - 1)) begin
                        w_fail_nx  = FW'(MAX_FAIL);
                        w_load     = 1'b1;
                        w_load_val = LOCKOUT_CYCLES;
                        w_state_nx = ST_LOCKOUT;
                    end else begin
                        w_fail_nx  = r_fail + FW'(1);
                        w_state_nx = ST_ENTRY;
                    end
                end
            end
            ST_OPEN: begin
                if (w_expire || w_hash) begin
                    w_state_nx = ST_ENTRY;
                end else if (w_star) begin
                    w_load     = 1'b1;
                    w_state_nx = ST_SETPW;
                end
            end
            ST_SETPW: begin
                if (w_expire) begin
                    w_state_nx = ST_ENTRY;
                    w_buf_nx   = '0;
                    w_cnt_nx   = '0;
                end else if (w_digit || w_star || w_hash) begin
                    w_load = 1'b1;
                    if (w_digit) begin
                        if (!w_full) begin
                            w_buf_nx = w_pushed;
                            w_cnt_nx = r_cnt + 4'd1;
                        end
                    end else begin
                        w_buf_nx = '0;
                        w_cnt_nx = '0;
                        if (w_star) begin
                            w_state_nx = ST_OPEN;
                        end else if (w_full) begin
                            w_pw_nx    = r_buf;
                            w_ok_nx    = 1'b1;
                            w_state_nx = ST_OPEN;
                        end else begin
                            w_err_nx = 1'b1;
                        end
                    end
                end
            end
            ST_LOCKOUT: begin
                if (w_expire) begin
                    w_fail_nx  = '0;
                    w_state_nx = ST_ENTRY;
                end
            end
            default: w_state_nx = ST_ENTRY;
        endcase
    end

    assign bus.unlocked  = (r_state == ST_OPEN) || (r_state == ST_SETPW);
    assign bus.alarm     = (r_state == ST_LOCKOUT);
    assign bus.ok_pulse  = r_ok;
    assign bus.err_pulse = r_err;
    assign bus.entry_cnt = r_cnt;
    assign bus.entry_buf = r_buf;
    assign bus.st        = r_state;
endmodule

// File: tb/tb_lock_ctrl.sv
// Directed bench for lock_ctrl with a per-cycle behavioural reference model.
module tb_lock_ctrl;
    localparam int PW_LEN   = 4;
    localparam int OPEN_N   = 20;
    localparam int LOCK_N   = 50;
    localparam int MAX_FAIL = 3;
    localparam int M_ENTRY = 0, M_CHECK = 1, M_OPEN = 2, M_SETPW = 3, M_LOCK = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    lock_ctrl_if #(.PW_LEN(PW_LEN)) bus ();

    lock_ctrl #(
        .PW_LEN         (PW_LEN),
        .DEFAULT_PW     (16'h1234),
        .MAX_FAIL       (MAX_FAIL),
        .OPEN_CYCLES    (32'd20),
        .LOCKOUT_CYCLES (32'd50)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode, digit queue, stored password and an absolute
    // deadline cycle for the timed modes.
    int                   m_mode  = M_ENTRY;
    int                   m_cyc   = 0;
    int                   m_dead  = -1;
    int                   m_fails = 0;
    int                   m_q[$];
    logic [PW_LEN*4-1:0]  m_pw    = 16'h1234;
    bit                   m_ok    = 0;
    bit                   m_err   = 0;

    function automatic logic [PW_LEN*4-1:0] m_bufval();
        logic [PW_LEN*4-1:0] v;
        v = '0;
        foreach (m_q[i]) v = (v << 4) | (PW_LEN*4)'(m_q[i]);
        return v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode  = M_ENTRY;
            m_q.delete();
            m_pw    = 16'h1234;
            m_fails = 0;
            m_ok    = 0;
            m_err   = 0;
            m_dead  = -1;
        end else begin : step
            bit kv, dig, star, hash, due;
            int kc;
            kv   = bus.key_valid;
            kc   = int'(bus.key_code);
            dig  = kv && (kc <= 9);
            star = kv && (kc == 10);
            hash = kv && (kc == 11);
            m_cyc++;
            due   = (m_cyc == m_dead);
            m_ok  = 0;
            m_err = 0;
            case (m_mode)
                M_ENTRY: begin
                    if (dig) begin
                        if (m_q.size() < PW_LEN) m_q.push_back(kc);
                    end else if (star) m_q.delete();
                    else if (hash) begin
                        if (m_q.size() == PW_LEN) m_mode = M_CHECK;
                        else begin m_err = 1; m_q.delete(); end
                    end
                end
                M_CHECK: begin
                    if (m_bufval() == m_pw) begin
                        m_ok = 1; m_fails = 0; m_mode = M_OPEN; m_dead = m_cyc + OPEN_N;
                    end else begin
                        m_err = 1;
                        m_fails = (m_fails + 1 > MAX_FAIL) ? MAX_FAIL : m_fails + 1;
                        if (m_fails == MAX_FAIL) begin
                            m_mode = M_LOCK; m_dead = m_cyc + LOCK_N;
                        end else m_mode = M_ENTRY;
                    end
                    m_q.delete();
                end
                M_OPEN: begin
                    if (due || hash) m_mode = M_ENTRY;
                    else if (star) begin m_mode = M_SETPW; m_dead = m_cyc + OPEN_N; end
                end
                M_SETPW: begin
                    if (due) begin
                        m_mode = M_ENTRY; m_q.delete();
                    end else if (dig || star || hash) begin
                        m_dead = m_cyc + OPEN_N;
                        if (dig) begin
                            if (m_q.size() < PW_LEN) m_q.push_back(kc);
                        end else if (star) begin
                            m_mode = M_OPEN; m_q.delete();
                        end else begin
                            if (m_q.size() == PW_LEN) begin
                                m_pw = m_bufval(); m_ok = 1; m_mode = M_OPEN;
                            end else m_err = 1;
                            m_q.delete();
                        end
                    end
                end
                M_LOCK: if (due) begin m_fails = 0; m_mode = M_ENTRY; end
                default: m_mode = M_ENTRY;
            endcase
        end
    end

    always @(negedge clk) begin
        chk("cmp_st",        32'(bus.st),        32'(m_mode));
        chk("cmp_unlocked",  32'(bus.unlocked),  32'(m_mode == M_OPEN || m_mode == M_SETPW));
        chk("cmp_alarm",     32'(bus.alarm),     32'(m_mode == M_LOCK));
        chk("cmp_ok",        32'(bus.ok_pulse),  32'(m_ok));
        chk("cmp_err",       32'(bus.err_pulse), 32'(m_err));
        chk("cmp_entry_cnt", 32'(bus.entry_cnt), 32'(m_q.size()));
        chk("cmp_entry_buf", 32'(bus.entry_buf), 32'(m_bufval()));
    end

    task automatic press(input int k);
        bus.key_valid = 1'b1;
        bus.key_code  = 4'(k);
        @(negedge clk);
        bus.key_valid = 1'b0;
    endtask

    task automatic type_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] == "*")      press(10);
            else if (s[i] == "#") press(11);
            else                  press(int'(s[i]) - 48);
        end
    endtask

    int n;

    initial begin
        bus.key_valid = 1'b0;
        bus.key_code  = 4'd0;
        repeat (3) @(negedge clk);
        chk("rst_st", 32'(bus.st), 0);
        chk("rst_unlocked", 32'(bus.unlocked), 0);
        chk("rst_entry_cnt", 32'(bus.entry_cnt), 0);
        #1 rst_n = 1'b1;
        @(negedge clk);

        // correct password, then idle timeout
        type_str("1234#");
        chk("t1_check_st", 32'(bus.st), 1);
        @(negedge clk);
        chk("t1_ok", 32'(bus.ok_pulse), 1);
        chk("t1_unlocked", 32'(bus.unlocked), 1);
        n = 1;
        while (n < 100) begin
            @(negedge clk);
            if (!bus.unlocked) break;
            n++;
        end
        chk("t1_open_len", n, OPEN_N);

        // short entry and overflow drop
        type_str("12#");
        chk("t2_err", 32'(bus.err_pulse), 1);
        chk("t2_cnt", 32'(bus.entry_cnt), 0);
        chk("t2_st", 32'(bus.st), 0);
        type_str("12345");
        chk("t2_cnt4", 32'(bus.entry_cnt), 4);
        chk("t2_buf", 32'(bus.entry_buf), 32'h1234);
        type_str("*");

        // three failures -> lockout, keys hammered during lockout
        for (int i = 0; i < 3; i++) begin
            type_str("9999#");
            @(negedge clk);
            chk("t3_err", 32'(bus.err_pulse), 1);
            chk("t3_alarm", 32'(bus.alarm), (i == 2) ? 1 : 0);
        end
        n = 1;
        while (n < 200) begin
            @(negedge clk);
            if (!bus.alarm) break;
            n++;
            bus.key_valid = 1'b1;
            bus.key_code  = 4'(n % 12);
        end
        bus.key_valid = 1'b0;
        chk("t3_lock_len", n, LOCK_N);
        chk("t3_cnt_after", 32'(bus.entry_cnt), 0);
        type_str("1234#");
        @(negedge clk);
        chk("t3_unlock", 32'(bus.unlocked), 1);

        // aborted password change, then idle relock
        type_str("*56*");
        chk("t6_st", 32'(bus.st), 2);
        chk("t6_cnt", 32'(bus.entry_cnt), 0);
        n = 1;
        while (n < 100) begin
            @(negedge clk);
            if (!bus.unlocked) break;
            n++;
        end
        chk("t6_idle_len", n, OPEN_N);
        type_str("1234#");
        @(negedge clk);
        chk("t6_old_pw", 32'(bus.unlocked), 1);

        // change password to 5678
        type_str("*5678#");
        chk("t5_ok", 32'(bus.ok_pulse), 1);
        chk("t5_st", 32'(bus.st), 2);
        type_str("#");
        chk("t5_relock", 32'(bus.st), 0);
        type_str("1234#");
        @(negedge clk);
        chk("t5_old_rejected", 32'(bus.err_pulse), 1);
        type_str("5678#");
        @(negedge clk);
        chk("t5_new_accepted", 32'(bus.unlocked), 1);

        // reset mid-OPEN restores the default password
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #2;
        chk("t7_unlocked", 32'(bus.unlocked), 0);
        chk("t7_st", 32'(bus.st), 0);
        chk("t7_alarm", 32'(bus.alarm), 0);
        chk("t7_ok_err", {30'd0, bus.ok_pulse, bus.err_pulse}, 0);
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        type_str("1234#");
        @(negedge clk);
        chk("t7_unlock", 32'(bus.unlocked), 1);

        // unused key codes
        press(13);
        chk("t8_open_13", 32'(bus.st), 2);
        type_str("#");
        press(1);
        press(13);
        chk("t8_cnt_13", 32'(bus.entry_cnt), 1);
        type_str("*");

        // '#' on the SETPW expiry cycle is dropped
        type_str("1234#");
        @(negedge clk);
        type_str("*9876");
        repeat (OPEN_N - 1) @(negedge clk);
        press(11);
        chk("t9_st", 32'(bus.st), 0);
        chk("t9_ok", 32'(bus.ok_pulse), 0);
        type_str("1234#");
        @(negedge clk);
        chk("t9_pw_kept", 32'(bus.unlocked), 1);
        type_str("#");
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
